// File: rtl/riscv_pkg.sv
// Shared core definitions used by the pipeline interlock logic.
package riscv_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_FLUSH = 1'b1
    } hazard_state_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write counters with busy lookups for the hazard controller.
module hazard_scoreboard
    import riscv_pkg::*;
#(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic [REG_ADDR_W-1:0] inc_addr,
    input  logic                  wb_write,
    input  logic [REG_ADDR_W-1:0] wb_waddr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rd_full,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]    count [NUM_REGS];
    logic [NUM_REGS-1:0] inc_hit;
    logic [NUM_REGS-1:0] dec_hit;
    logic                dec;

    assign dec = wb_write && (wb_waddr != '0);

    // x0 is excluded from both hit vectors, so its counter stays at zero
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        assign inc_hit[r]   = inc && (inc_addr == REG_ADDR_W'(r)) && (r != 0);
        assign dec_hit[r]   = dec && (wb_waddr == REG_ADDR_W'(r));
        assign busy_mask[r] = (count[r] != '0);
    end

    // With write-through, a register whose last pending write retires now reads as free
    always_comb begin
        rs1_busy = (count[rs1_addr] != '0);
        rs2_busy = (count[rs2_addr] != '0);
        rd_full  = (count[rd_addr] == CNT_MAX);
        if (WB_BYPASS && wb_write && (wb_waddr == rs1_addr) && (count[rs1_addr] == CNT_ONE))
            rs1_busy = 1'b0;
        if (WB_BYPASS && wb_write && (wb_waddr == rs2_addr) && (count[rs2_addr] == CNT_ONE))
            rs2_busy = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) count[r] <= '0;
            err <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (inc_hit[r] && !dec_hit[r])
                    count[r] <= count[r] + CNT_ONE;
                else if (dec_hit[r] && !inc_hit[r] && (count[r] != '0))
                    count[r] <= count[r] - CNT_ONE;
            end
            if (dec && (count[wb_waddr] == '0))
                err <= 1'b1;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock/redirect sequencer: RAW stalls via the scoreboard, timed IF/ID flush.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int CNT_W        = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter bit WB_BYPASS    = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic                  id_rs1_used_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_rd_write_i,
    input  logic                  ex_redirect_i,
    input  logic                  wb_write_i,
    input  logic [REG_ADDR_W-1:0] wb_waddr_i,
    input  logic                  ext_stall_i,
    output logic                  if_stall_o,
    output logic                  id_stall_o,
    output logic                  ex_bubble_o,
    output logic                  if_flush_o,
    output logic                  id_flush_o,
    output logic [31:0]           busy_mask_o,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           flush_cnt_o,
    output logic                  err_o
);
    localparam int                REM_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [REM_W-1:0]  REM_RELOAD = REM_W'(FLUSH_CYCLES - 1);
    localparam logic [REM_W-1:0]  REM_ONE    = REM_W'(1);

    hazard_state_t    state, state_nxt;
    logic [REM_W-1:0] rem, rem_nxt;

    logic rs1_busy, rs2_busy, rd_full;
    logic hazard, issue, stall, bubble, flush;
    logic stall_inc, flush_inc;

    hazard_scoreboard #(
        .CNT_W     (CNT_W),
        .WB_BYPASS (WB_BYPASS)
    ) u_scoreboard (
        .clk       (clk_i),
        .rst       (rst_i),
        .inc       (issue && id_rd_write_i),
        .inc_addr  (id_rd_i),
        .wb_write  (wb_write_i),
        .wb_waddr  (wb_waddr_i),
        .rs1_addr  (id_rs1_i),
        .rs2_addr  (id_rs2_i),
        .rd_addr   (id_rd_i),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rd_full   (rd_full),
        .busy_mask (busy_mask_o),
        .err       (err_o)
    );

    assign hazard = id_valid_i &&
                    ((id_rs1_used_i && (id_rs1_i != '0) && rs1_busy) ||
                     (id_rs2_used_i && (id_rs2_i != '0) && rs2_busy) ||
                     (id_rd_write_i && (id_rd_i  != '0) && rd_full));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= HZ_RUN;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    // Redirect outranks everything; the flush window only counts down while the core is not frozen
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        stall     = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        issue     = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (ex_redirect_i) begin
            flush     = 1'b1;
            bubble    = 1'b1;
            flush_inc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = HZ_FLUSH;
                rem_nxt   = REM_RELOAD;
            end else begin
                state_nxt = HZ_RUN;
            end
        end else if (state == HZ_FLUSH) begin
            flush  = 1'b1;
            bubble = 1'b1;
            if (!ext_stall_i) begin
                rem_nxt = rem - REM_ONE;
                if (rem == REM_ONE) state_nxt = HZ_RUN;
            end
        end else begin
            stall     = hazard || ext_stall_i;
            bubble    = hazard && !ext_stall_i;
            issue     = id_valid_i && !hazard && !ext_stall_i;
            stall_inc = hazard;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_inc) stall_cnt_o <= stall_cnt_o + 32'd1;
            if (flush_inc) flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end

    // Combinational controls are forced low while reset is held
    assign if_stall_o  = !rst_i && stall;
    assign id_stall_o  = !rst_i && stall;
    assign ex_bubble_o = !rst_i && bubble;
    assign if_flush_o  = !rst_i && flush;
    assign id_flush_o  = !rst_i && flush;
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline interlock and sequencing controller for the IF/ID/EX/WB core. It keeps a per-register scoreboard of in-flight writes. Issue is blocked on read-after-write hazards (there is no forwarding), with a NOP inserted into EX. On a taken branch/jump signalled from EX, it drives IF/ID flush for a fixed number of cycles. Sits beside the stages at core top level; its outputs gate stage register enables and bubble muxes.

Parameters:
CNT_W, 2, width of each per-register pending-write counter (max in-flight writes per register = 2^CNT_W-1)
FLUSH_CYCLES, 2, cycles IF/ID flush is held per redirect (>=1), including the redirect cycle
WB_BYPASS, 0, 1 = regfile writes through in the same cycle, so a register retiring with count 1 is treated as free

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
id_valid_i  in  1  ID holds a valid instruction
id_rs1_i  in  5  ID source 1 address
id_rs1_used_i  in  1  instruction reads rs1
id_rs2_i  in  5  ID source 2 address
id_rs2_used_i  in  1  instruction reads rs2
id_rd_i  in  5  ID destination address
id_rd_write_i  in  1  instruction writes rd
ex_redirect_i  in  1  EX resolved taken branch/jump this cycle
wb_write_i  in  1  WB writes regfile this cycle
wb_waddr_i  in  5  WB write address
ext_stall_i  in  1  external freeze (e.g. memory busy)
if_stall_o  out  1  hold PC/IF register
id_stall_o  out  1  hold ID register
ex_bubble_o  out  1  load NOP into EX
if_flush_o  out  1  invalidate IF output
id_flush_o  out  1  invalidate ID register
busy_mask_o  out  32  bit r = count[r]!=0
stall_cnt_o  out  32  hazard stall cycles, wraps
flush_cnt_o  out  32  redirects accepted, wraps
err_o  out  1  sticky scoreboard underflow

Behaviour:
- Reset (async, rst_i=1): all counts 0, state HZ_RUN, flush counter 0, stall_cnt/flush_cnt 0, err_o 0. All outputs 0 while in reset. Reset mid-flush or mid-stall aborts immediately.
- Registers x0: never marked and never a hazard source.
- busy(r) = count[r]!=0, except with WB_BYPASS=1 where it is false if wb_write_i & wb_waddr_i==r & count[r]==1.
- hazard (combinational) = id_valid_i & ((rs1_used & rs1!=0 & busy(rs1)) | (rs2_used & rs2!=0 & busy(rs2)) | (rd_write & rd!=0 & count[rd]==max)).
- State HZ_RUN, no redirect:
  - if_stall_o = id_stall_o = hazard | ext_stall_i.
  - ex_bubble_o = hazard & !ext_stall_i.
  - issue = id_valid_i & !hazard & !ext_stall_i.
- Redirect cycle (ex_redirect_i=1, any state, has priority over ext_stall_i and hazard):
  - if_flush_o = id_flush_o = ex_bubble_o = 1; no issue.
  - flush_cnt_o +1.
  - If FLUSH_CYCLES>1, go to HZ_FLUSH with remaining = FLUSH_CYCLES-1; else stay in HZ_RUN.
- State HZ_FLUSH:
  - if_flush_o = id_flush_o = ex_bubble_o = 1; no issue.
  - remaining decrements each cycle ext_stall_i=0 and is frozen while ext_stall_i=1.
  - Return to HZ_RUN after the cycle where remaining reaches 0.
  - A new redirect reloads remaining.
- Scoreboard update at clock edge:
  - inc = issue & rd_write & rd!=0; dec = wb_write_i & wb_waddr_i!=0.
  - inc and dec to the same register in one cycle: count unchanged.
  - dec with count 0: ignored, err_o set (sticky until reset).
  - inc never occurs at max (hazard blocks it).
- Stall latency: the instruction stalled on reg r issues in the cycle after WB writes r (WB_BYPASS=0), or in the same cycle as that write (WB_BYPASS=1).
- stall_cnt_o +1 per cycle with hazard=1 in HZ_RUN and no redirect. Both counters wrap modulo 2^32.

Decomposition:
- riscv_pkg additions:
  - hazard_state_t enum {HZ_RUN, HZ_FLUSH}
  - REG_ADDR_W=5, NUM_REGS=32.
- Sub-module hazard_scoreboard holds the count array, inc/dec/underflow logic, busy_mask and busy lookups.
- hazard_ctrl holds the FSM, stall/flush outputs and perf counters.

Test Plan:
1. Reset: assert rst_i mid-stall with count[5]=1 -> all outputs 0 and busy_mask_o=0 immediately; after release, rs1=5 does not stall.
2. RAW stall:
   - Stimulus: issue rd=5, then ID rs1=5 used; WB writes x5 three cycles later.
   - WB_BYPASS=0: id_stall_o=ex_bubble_o=1 for 4 cycles, issue in the cycle after the WB write, stall_cnt_o=4.
   - WB_BYPASS=1: same stimulus gives 3 stall cycles.
3. x0 and unused sources: issue rd=0 -> busy_mask_o=0; rs2=7 busy but id_rs2_used_i=0 -> no stall.
4. Redirect, FLUSH_CYCLES=2:
   - Single pulse -> flush outputs high exactly 2 cycles, flush_cnt_o=1.
   - Second pulse in the flush cycle -> 2 more cycles, flush_cnt_o=2.
   - ext_stall_i during flush extends it by the stalled cycles.
5. Simultaneous issue of rd=7 and WB of x7 with count[7]=1 -> count stays 1. With CNT_W=2 and count[9]=3, ID rd=9 -> stall until a WB of x9.
6. Underflow: wb_write x12 with count 0 -> err_o=1 and remains 1 across further traffic until rst_i.
